alu8_rr_sched: RTL
==================

// Module: alu8_rr_sched
// PURPOSE
//  - Time-shares one 8-bit logic/add datapath (AND, OR, XOR, ADD with carry) between 4 requesters.
//  - Round-robin arbitration; per-requester REQ/ACK handshake; operands latched at grant.
//  - The result is registered and delivered with a one-cycle ACK pulse.
//  - Sits between the 8-bit gate/adder library cells and any client needing occasional 8-bit ops.
// PARAMETERS
//  EXEC_CYCLES  1  wait states in EXEC before result capture; legal 1..15
//  PRIO_RESET   0  requester index the RR pointer holds after reset; legal 0..3
// PORTS
//  clk   in   1   single clock, rising edge
//  rst   in   1   asynchronous, active-high reset
//  REQ   in   4   REQ[i]=1: requester i wants an op; held until ACK[i]
//  OP    in   8   OP[2i+1:2i] = op of requester i: 00 AND, 01 OR, 10 XOR, 11 ADD
//  A     in   32  A[8i+7:8i] = operand A of requester i
//  B     in   32  B[8i+7:8i] = operand B of requester i
//  GNT   out  4   one-hot; requester owning the datapath (EXEC and RESP)
//  ACK   out  4   one-hot, one-cycle pulse; F/COUT valid for that requester
//  F     out  8   result; holds its value until the next RESP
//  COUT  out  1   carry of ADD; 0 for logic ops; holds like F
//  BUSY  out  1   1 when state != IDLE
// BEHAVIOUR
//  - Reset (async) values: state=IDLE, ptr=PRIO_RESET, GNT=0, ACK=0, F=8'h00, COUT=0, BUSY=0, cnt=0.
//  - States: IDLE, EXEC, RESP (2-bit encoding).
//  - IDLE, REQ==0: stay in IDLE.
//  - IDLE, REQ!=0:
//    - Select the first set bit scanning ptr, ptr+1, ... mod 4.
//    - Latch idx, op, A, B of that requester; GNT<=onehot(idx); cnt<=EXEC_CYCLES-1; go to EXEC.
//  - EXEC, cnt!=0: cnt<=cnt-1.
//  - EXEC, cnt==0:
//    - F/COUT <= core result of the latched operands; ACK<=onehot(idx); go to RESP.
//  - RESP: ACK cleared next edge; GNT<=0; ptr<=(idx+1) mod 4; go to IDLE.
//  - Latency: REQ sampled at edge k -> GNT from k, ACK high for 1 cycle after edge k+EXEC_CYCLES.
//  - Throughput: one op per EXEC_CYCLES+2 cycles; after RESP, IDLE is always spent 1 cycle.
//  - Operand capture: A/B/OP changes after grant are ignored; result uses latched values.
//  - REQ[i] dropped during EXEC: op still completes and ACK[i] still pulses (no abort).
//  - REQ[i] still high in IDLE after its ACK: treated as a new request; normal RR order applies.
//  - Fairness: a continuously requesting client waits at most 3 other ops.
//  - Width rules: ADD is {COUT,F}=A+B, 9-bit, no carry-in. AND/OR/XOR: bitwise, COUT=0.
//  - ptr wraps 3->0.
//  - rst mid-operation: immediate abort to reset values; no ACK for the aborted op.
//  - rst mid-operation: the requester must still hold REQ to be served after reset.
//  - No X on any output after reset; OP has no illegal codes.
// STRUCTURE
//  - Shared package alu8_pkg:
//    - op localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11.
//    - state localparams S_IDLE/S_EXEC/S_RESP; N_REQ=4.
//  - Sub-module alu8_core (combinational): F, COUT from A, B, OP.
//    - Built from the library and8b/or8b/xor8b/adder8b cells plus mux8_4to1b.
//  - Top module: RR pick function, FSM, wait counter, operand/result registers.
// TESTING
//  1. Reset, then REQ=0001, OP=11, A0=8'hF0, B0=8'h20 -> GNT=0001; after EXEC_CYCLES, F=8'h10, COUT=1, ACK=0001 for 1 cycle.
//  2. PRIO_RESET=0, REQ=4'b1111 held; each ACK'd requester keeps REQ -> ACK order 0,1,2,3,0; one op per EXEC_CYCLES+2 cycles.
//  3. Logic ops, requester 2: A=8'hA5, B=8'h0F with OP=00/01/10 -> F=8'h05/8'hAF/8'hAA; COUT=0 in all cases.
//  4. Requester 1 granted, then A1/OP1 changed and REQ[1] dropped in EXEC -> result uses latched values; ACK[1] still pulses.
//  5. rst asserted while in EXEC -> all outputs at reset values same cycle; no ACK; ptr=PRIO_RESET.
//  6. EXEC_CYCLES=4, REQ=1000, 8'hFF+8'h01 -> ACK 4 edges after grant; F=8'h00, COUT=1; BUSY high 5 cycles.

Source files
------------

// File: rtl/alu8_rr_sched_pkg.sv
// ============================================================================
// Module : alu8_pkg
// Brief  : Shared opcodes, FSM states and round-robin helpers for alu8_rr_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu8_pkg;

  localparam int N_REQ = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Walks from the farthest candidate back to ptr so the nearest set bit wins.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) idx = cand;
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu8_rr_sched_if.sv
// ============================================================================
// Module : alu8_rr_sched_if
// Brief  : Requester-side bus of the shared 8-bit ALU scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu8_rr_sched_if;
  import alu8_pkg::*;

  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] op;
  logic [8*N_REQ-1:0] a;
  logic [8*N_REQ-1:0] b;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         f;
  logic               cout;
  logic               busy;

  modport master (
    output req, op, a, b,
    input  gnt, ack, f, cout, busy
  );

  modport slave (
    input  req, op, a, b,
    output gnt, ack, f, cout, busy
  );

endinterface

`default_nettype wire

// File: rtl/alu8_rr_sched_core.sv
// ============================================================================
// Module : alu8_core (+ 8-bit gate/adder/mux library cells)
// Brief  : Combinational AND/OR/XOR/ADD datapath assembled from library cells.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module and8b (
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  output logic      [7:0] y
);
  assign y = a & b;
endmodule

module or8b (
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  output logic      [7:0] y
);
  assign y = a | b;
endmodule

module xor8b (
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  output logic      [7:0] y
);
  assign y = a ^ b;
endmodule

module adder8b (
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  output logic      [7:0] s,
  output logic            co
);
  assign {co, s} = {1'b0, a} + {1'b0, b};
endmodule

module mux8_4to1b (
  input  wire logic [7:0] d0,
  input  wire logic [7:0] d1,
  input  wire logic [7:0] d2,
  input  wire logic [7:0] d3,
  input  wire logic [1:0] sel,
  output logic      [7:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module alu8_core
  import alu8_pkg::*;
(
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  input  wire logic [1:0] op,
  output logic      [7:0] f,
  output logic            cout
);

  logic [7:0] w_and;
  logic [7:0] w_or;
  logic [7:0] w_xor;
  logic [7:0] w_sum;
  logic       w_co;

  and8b   u_and (.a(a), .b(b), .y(w_and));
  or8b    u_or  (.a(a), .b(b), .y(w_or));
  xor8b   u_xor (.a(a), .b(b), .y(w_xor));
  adder8b u_add (.a(a), .b(b), .s(w_sum), .co(w_co));

  // Mux inputs follow the opcode encoding so op drives sel directly.
  mux8_4to1b u_mux (
    .d0 (w_and),
    .d1 (w_or),
    .d2 (w_xor),
    .d3 (w_sum),
    .sel(op),
    .y  (f)
  );

  assign cout = (op == OP_ADD) ? w_co : 1'b0;

endmodule

`default_nettype wire

// File: rtl/alu8_rr_sched.sv
// ============================================================================
// Module : alu8_rr_sched
// Brief  : Round-robin time-sharing of one 8-bit ALU between four requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu8_rr_sched
  import alu8_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int PRIO_RESET  = 0
) (
  input wire logic   clk,
  input wire logic   rst,
  alu8_rr_sched_if.slave bus
);

  localparam logic [1:0] c_ptr_rst  = 2'(PRIO_RESET);
  localparam logic [3:0] c_cnt_load = 4'(EXEC_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_idx;
  logic [1:0]       r_op;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [3:0]       r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_ack;
  logic [7:0]       r_f;
  logic             r_cout;

  logic [1:0]       w_pick;
  logic [7:0]       w_f;
  logic             w_cout;

  assign w_pick = rr_pick(bus.req, r_ptr);

  // The core only ever sees latched operands, so late bus changes cannot leak in.
  alu8_core u_core (
    .a   (r_a),
    .b   (r_b),
    .op  (r_op),
    .f   (w_f),
    .cout(w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= c_ptr_rst;
      r_idx   <= 2'd0;
      r_op    <= OP_AND;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_cnt   <= 4'd0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_f     <= 8'h00;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_idx   <= w_pick;
            r_op    <= bus.op[{w_pick, 1'b0} +: 2];
            r_a     <= bus.a[{w_pick, 3'b000} +: 8];
            r_b     <= bus.b[{w_pick, 3'b000} +: 8];
            r_gnt   <= onehot(w_pick);
            r_cnt   <= c_cnt_load;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_f     <= w_f;
            r_cout  <= w_cout;
            r_ack   <= onehot(r_idx);
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ack   <= '0;
          r_gnt   <= '0;
          r_ptr   <= r_idx + 2'd1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.ack  = r_ack;
  assign bus.f    = r_f;
  assign bus.cout = r_cout;
  assign bus.busy = (r_state != S_IDLE);

endmodule

`default_nettype wire
